alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
- Upstream issue stage for the 4-bit ALU (ops ADD/SUB/AND/OR/NOT, outputs Result + Zero).
- Accepts instructions over a valid/ready handshake and reads operands from a 4x4-bit register file.
- Drives registered A/B/ALUOp into the combinational ALU, then writes the ALU Result back to the register file and latches the Zero flag.
- Completes one instruction every 2 cycles, no overlap.

Parameters:
- DATA_W, 4, operand/result width; must match the ALU.
- NREGS, 4, register-file depth; register address width is clog2(NREGS).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  block can accept an instruction.
- in_op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT, 101 LOADI, 110/111 illegal.
- in_rd, in_rs1, in_rs2  in  2 each  destination and source register indices.
- in_imm  in  DATA_W  immediate, used by LOADI only.
- alu_a, alu_b  out  DATA_W  ALU operands, registered.
- alu_op  out  3  ALU opcode, registered.
- alu_result  in  DATA_W  ALU Result.
- alu_zero  in  1  ALU Zero.
- wb_valid  out  1  one-cycle pulse per retired instruction.
- wb_rd  out  2  register written.
- wb_data  out  DATA_W  value written.
- zero_flag  out  1  sticky copy of the last ALU Zero.
- illegal  out  1  pulses together with wb_valid for opcode 110/111.
- dbg_addr  in  2  debug read address.
- dbg_data  out  DATA_W  combinational read of rf[dbg_addr].

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; all rf entries = 0.
  - alu_a = alu_b = 0, alu_op = 000.
  - wb_valid, wb_rd, wb_data, zero_flag and illegal = 0.
- FSM states: IDLE, EXEC.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture op/rd/imm; load alu_a = rf[rs1], alu_b = rf[rs2], alu_op = in_op[2:0]; go to EXEC.
  - Otherwise stay in IDLE.
- EXEC (exactly 1 cycle):
  - in_ready = 0; the ALU settles combinationally.
  - At the closing edge, by opcode:
    - Ops 000-100: rf[rd] <= alu_result; zero_flag <= alu_zero.
    - LOADI: rf[rd] <= imm; zero_flag is unchanged.
    - 110/111: no rf write; zero_flag unchanged; illegal <= 1.
  - For every opcode: wb_valid <= 1, wb_rd <= rd, wb_data <= written value (0 when illegal); FSM returns to IDLE.
- wb_valid and illegal are high for exactly one cycle, during the IDLE cycle that follows EXEC.
- Latency: accept edge N -> rf updated at edge N+1 -> wb_valid high during cycle N+1..N+2.
- Throughput: 1 instruction per 2 cycles.
- NOT uses alu_a only; alu_b is still loaded from rs2 and ignored.
- Arithmetic is modulo 2^DATA_W; there is no carry or overflow output.
- Back-to-back dependency, e.g. rd of instr k equals rs1 of instr k+1: the write at the EXEC edge precedes the next IDLE capture, so no hazard logic is required.
- An in_valid held during EXEC is not accepted until the next IDLE cycle; inputs must stay stable while in_valid=1 & in_ready=0.
- rd == rs1 == rs2 is legal: operands are read before the write.
- Reset asserted mid-EXEC aborts the instruction: no write and no wb_valid.

Optional Feature:
- Macro ALU_RETIRE_CNT_EN.
- Defined: adds output retire_cnt [15:0], reset 0, incremented on every wb_valid (illegal ops included), wraps 0xFFFF -> 0.
- Undefined: port and counter are absent.

Decomposition:
- Package alu_pkg:
  - Opcode constants OP_ADD..OP_NOT, OP_LOADI.
  - DATA_W default.
  - FSM state typedef.
- One sub-module, alu_regfile:
  - NREGS x DATA_W, async reset to 0.
  - Two combinational read ports plus the dbg read port.
  - One synchronous write port.
- The ALU itself stays external.

Test Plan:
- Reset, then read all dbg_addr -> 0; in_ready=1; wb_valid=0; zero_flag=0.
- LOADI r1=0101, LOADI r2=0011, ADD r3=r1+r2 -> wb_data=1000, rf[3]=1000, zero_flag=0, wb_valid one cycle after the EXEC edge.
- SUB r0=r1-r1 -> rf[0]=0000, zero_flag=1; then AND r0=r1&r2 (0001) -> zero_flag=0. OR r1|r2 -> 0111; NOT r1 -> 1010.
- in_valid held high continuously -> accepts exactly every other cycle; dependent chain ADD r1=r1+r1 ×3 starting from 0001 -> 0010, 0100, 1000.
- Op 110 to r2 -> illegal=1 and wb_valid=1 for one cycle, rf[2] and zero_flag unchanged; with ALU_RETIRE_CNT_EN, retire_cnt increments.
- Assert rst_n low during EXEC of ADD r3 -> no wb_valid, rf cleared, FSM returns to IDLE with in_ready=1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, widths and FSM state type for the ALU issue stage
package alu_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_NREGS  = 4;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_NOT   = 3'b100;
  localparam logic [2:0] OP_LOADI = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  // Opcodes 110 and 111 have no defined operation.
  function automatic logic is_illegal(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - NREGS x DATA_W register file, two operand read ports, one debug read port, one write port
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = DEF_NREGS,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] rf_q [NREGS];
  logic [DATA_W-1:0] rf_d [NREGS];

  always_comb begin
    rf_d = rf_q;
    if (we) rf_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // Reads see the pre-write contents, so rd == rs1 == rs2 needs no special case.
  assign rdata1   = rf_q[raddr1];
  assign rdata2   = rf_q[raddr2];
  assign dbg_data = rf_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - two-cycle issue/writeback controller for the external 4-bit ALU
// Optional retire counter output enabled by ALU_RETIRE_CNT_EN.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = DEF_NREGS,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [AW-1:0]     in_rd,
  input  logic [AW-1:0]     in_rs1,
  input  logic [AW-1:0]     in_rs2,
  input  logic [DATA_W-1:0] in_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              wb_valid,
  output logic [AW-1:0]     wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              zero_flag,
  output logic              illegal,
`ifdef ALU_RETIRE_CNT_EN
  output logic [15:0]       retire_cnt,
`endif
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic              wb_valid_q, wb_valid_d;
  logic [AW-1:0]     wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              zero_flag_q, zero_flag_d;
  logic              illegal_q, illegal_d;

  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rs1_data, rs2_data;

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .AW     (AW)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (rd_q),
    .wdata    (rf_wdata),
    .raddr1   (in_rs1),
    .rdata1   (rs1_data),
    .raddr2   (in_rs2),
    .rdata2   (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  assign in_ready = (state_q == ST_IDLE);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    zero_flag_d = zero_flag_q;
    illegal_d   = 1'b0;
    rf_we       = 1'b0;
    rf_wdata    = alu_result;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d     = in_op;
          rd_d     = in_rd;
          imm_d    = in_imm;
          alu_a_d  = rs1_data;
          alu_b_d  = rs2_data;
          alu_op_d = in_op;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d    = ST_IDLE;
        wb_valid_d = 1'b1;
        wb_rd_d    = rd_q;
        if (is_illegal(op_q)) begin
          illegal_d = 1'b1;
          wb_data_d = '0;
        end else if (op_q == OP_LOADI) begin
          rf_we     = 1'b1;
          rf_wdata  = imm_q;
          wb_data_d = imm_q;
        end else begin
          rf_we       = 1'b1;
          wb_data_d   = alu_result;
          zero_flag_d = alu_zero;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ADD;
      rd_q        <= '0;
      imm_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= OP_ADD;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      zero_flag_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      zero_flag_q <= zero_flag_d;
      illegal_q   <= illegal_d;
    end
  end

`ifdef ALU_RETIRE_CNT_EN
  logic [15:0] retire_cnt_q, retire_cnt_d;

  // Counts at the same edge that raises wb_valid, so the value is current during the pulse.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (wb_valid_d) retire_cnt_d = retire_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retire_cnt_q <= '0;
    else        retire_cnt_q <= retire_cnt_d;
  end

  assign retire_cnt = retire_cnt_q;
`endif

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign zero_flag = zero_flag_q;
  assign illegal   = illegal_q;

endmodule
